// File: rtl/delay_pkg.sv
// Shared definitions for the multi-channel programmable delay timer.
package delay_pkg;

    // Per-channel FSM encoding.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Width of a channel-select field for n channels; never narrower than one bit.
    function automatic int chan_sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NCH_DEF   = 4;
    localparam int LOAD_CH_W = chan_sel_w(NCH_DEF);

endpackage

// File: rtl/delay_chan.sv
// One delay channel: limit register, up-counter, IDLE/RUN FSM and registered busy/done.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | waiting for trig; count held at zero
//   ST_RUN  | counting toward limit; done pulses when count >= limit
module delay_chan
    import delay_pkg::*;
#(
    parameter int CW        = 26,
    parameter int DEF_LIMIT = 200
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          trig,
    input  logic          cancel,
    input  logic          retrig_en,
    input  logic          load_we,
    input  logic [CW-1:0] load_val,
    output logic          busy,
    output logic          done,
    output logic          done_nxt
);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] limit_q;
    logic [CW-1:0] limit_eff;
    logic          done_q, done_d;

    // A load landing this cycle already governs this cycle's completion compare.
    assign limit_eff = load_we ? load_val : limit_q;

    // State, counter, limit and done registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
            limit_q <= CW'(DEF_LIMIT);
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
            if (load_we) begin
                limit_q <= load_val;
            end
        end
    end

    // Next state: cancel beats retrigger beats completion beats increment.
    always_comb begin
        state_d = state_q;
        count_d = '0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig && !cancel) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else if (retrig_en && trig) begin
                    state_d = ST_RUN;
                end else if (count_q >= limit_eff) begin
                    done_d  = 1'b1;
                    state_d = trig ? ST_RUN : ST_IDLE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs come straight from registers; done_nxt lets the top register done_any alongside done.
    always_comb begin
        busy     = (state_q == ST_RUN);
        done     = done_q;
        done_nxt = done_d;
    end

endmodule

// File: rtl/delay_timer_multi.sv
// Multi-channel programmable delay: NCH independent channels, shared limit-load port,
// and a registered OR of all done pulses.
module delay_timer_multi
    import delay_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int CW        = 26,
    parameter int DEF_LIMIT = 200
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NCH-1:0]             trig,
    input  logic [NCH-1:0]             cancel,
    input  logic [NCH-1:0]             retrig_en,
    input  logic                       load_en,
    input  logic [chan_sel_w(NCH)-1:0] load_ch,
    input  logic [CW-1:0]              load_val,
    output logic [NCH-1:0]             busy,
    output logic [NCH-1:0]             done,
    output logic                       done_any
);

    localparam int LCW = chan_sel_w(NCH);

    logic [NCH-1:0] load_we;
    logic [NCH-1:0] done_nxt;
    logic           done_any_q;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        // Out-of-range load_ch matches no channel, so such writes fall away.
        assign load_we[i] = load_en && (load_ch == LCW'(i));

        delay_chan #(
            .CW        (CW),
            .DEF_LIMIT (DEF_LIMIT)
        ) u_chan (
            .CLK       (CLK),
            .RST       (RST),
            .trig      (trig[i]),
            .cancel    (cancel[i]),
            .retrig_en (retrig_en[i]),
            .load_we   (load_we[i]),
            .load_val  (load_val),
            .busy      (busy[i]),
            .done      (done[i]),
            .done_nxt  (done_nxt[i])
        );
    end

    // done_any is registered from the same next-values as done so both rise together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            done_any_q <= 1'b0;
        end else begin
            done_any_q <= |done_nxt;
        end
    end

    assign done_any = done_any_q;

endmodule

// File: tb/tb_delay_timer_multi.sv
// Scoreboard bench for delay_timer_multi: stimulus pushes expected done events
// (cycle, channel mask); a negedge monitor pops and compares them.
module tb_delay_timer_multi;

    localparam int NCH = 4;
    localparam int CW  = 26;

    logic           CLK;
    logic           RST;
    logic [NCH-1:0] trig;
    logic [NCH-1:0] cancel;
    logic [NCH-1:0] retrig_en;
    logic           load_en;
    logic [1:0]     load_ch;
    logic [CW-1:0]  load_val;
    logic [NCH-1:0] busy;
    logic [NCH-1:0] done;
    logic           done_any;

    delay_timer_multi #(.NCH(NCH), .CW(CW), .DEF_LIMIT(200)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .trig      (trig),
        .cancel    (cancel),
        .retrig_en (retrig_en),
        .load_en   (load_en),
        .load_ch   (load_ch),
        .load_val  (load_val),
        .busy      (busy),
        .done      (done),
        .done_any  (done_any)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        int             c;
        logic [NCH-1:0] d;
    } exp_t;

    exp_t expq[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Insert an expected done mask at observation cycle c, merging same-cycle entries.
    function automatic void push_exp(input int c, input logic [NCH-1:0] d);
        for (int k = 0; k < expq.size(); k++) begin
            if (expq[k].c == c) begin
                expq[k].d = expq[k].d | d;
                return;
            end
            if (expq[k].c > c) begin
                expq.insert(k, '{c: c, d: d});
                return;
            end
        end
        expq.push_back('{c: c, d: d});
    endfunction

    // Monitor: any done activity must match the head of the scoreboard.
    always @(negedge CLK) begin
        exp_t e;
        if (!RST) begin
            while (expq.size() > 0 && expq[0].c < cyc) begin
                e = expq.pop_front();
                n_chk++;
                n_fail++;
                $display("FAIL done_missed: saw nothing, required done=%b at cycle %0d (now %0d)", e.d, e.c, cyc);
            end
            if (done != '0 || done_any) begin
                n_chk++;
                if (expq.size() == 0 || expq[0].c != cyc) begin
                    n_fail++;
                    $display("FAIL done_unexpected: got done=%b done_any=%b at cycle %0d, required none", done, done_any, cyc);
                end else begin
                    e = expq.pop_front();
                    if (done !== e.d || done_any !== 1'b1) begin
                        n_fail++;
                        $display("FAIL done_value: cycle %0d got done=%b done_any=%b, required done=%b done_any=1", cyc, done, done_any, e.d);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic check(input string name, input logic [NCH-1:0] got, input logic [NCH-1:0] req);
        n_chk++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %b required %b at cycle %0d", name, got, req, cyc);
        end
    endtask

    task automatic load(input int ch, input int v);
        load_en  = 1'b1;
        load_ch  = ch[1:0];
        load_val = v[CW-1:0];
        tick();
        load_en  = 1'b0;
    endtask

    int c;
    int guard;

    initial begin
        RST = 1'b1; trig = '0; cancel = '0; retrig_en = '0;
        load_en = 1'b0; load_ch = '0; load_val = '0;
        repeat (3) tick();
        RST = 1'b0;
        check("reset_busy", busy, 4'b0000);
        check("reset_done", {done[3:1], done[0] | done_any}, 4'b0000);
        tick();

        // 1: reset mid-run of ch0, then default limits observed through timing
        trig = 4'b0001; tick(); trig = '0;
        repeat (50) tick();
        check("run_busy0", busy, 4'b0001);
        RST = 1'b1;
        #1;
        check("rst_async_busy", busy, 4'b0000);
        check("rst_async_done", {done[3:1], done[0] | done_any}, 4'b0000);
        tick(); tick();
        RST = 1'b0;
        repeat (210) tick();
        c = cyc;
        trig = 4'b1111;
        push_exp(c + 202, 4'b1111);
        tick(); trig = '0;
        repeat (200) tick();
        check("def_limit_busy_hi", busy, 4'b1111);
        tick();
        check("def_limit_busy_lo", busy, 4'b0000);
        tick();

        // 2: basic latency, limit 5
        load(1, 5);
        c = cyc;
        trig = 4'b0010;
        push_exp(c + 7, 4'b0010);
        tick(); trig = '0;
        check("lat_busy_start", busy, 4'b0010);
        repeat (5) tick();
        check("lat_busy_end", busy, 4'b0010);
        tick();
        check("lat_busy_off", busy, 4'b0000);
        repeat (3) tick();

        // 3: retrigger enabled, then disabled
        load(2, 10);
        retrig_en = 4'b0100;
        c = cyc;
        trig = 4'b0100;
        push_exp(c + 19, 4'b0100);
        tick(); trig = '0;
        repeat (6) tick();
        trig = 4'b0100; tick(); trig = '0;
        repeat (14) tick();
        retrig_en = '0;
        c = cyc;
        trig = 4'b0100;
        push_exp(c + 12, 4'b0100);
        tick(); trig = '0;
        repeat (6) tick();
        trig = 4'b0100; tick(); trig = '0;
        repeat (10) tick();
        check("noretrig_idle", busy, 4'b0000);

        // 4: cancel at count 12, then trig+cancel from IDLE
        load(3, 20);
        c = cyc;
        trig = 4'b1000; tick(); trig = '0;
        repeat (12) tick();
        check("cancel_pre_busy", busy, 4'b1000);
        cancel = 4'b1000; tick(); cancel = '0;
        check("cancel_busy", busy, 4'b0000);
        repeat (25) tick();
        trig = 4'b1000; cancel = 4'b1000; tick(); trig = '0; cancel = '0;
        check("trig_cancel_idle", busy, 4'b0000);
        repeat (25) tick();

        // 5: lower limit below running count, then limit 0
        load(0, 100);
        c = cyc;
        trig = 4'b0001; tick(); trig = '0;
        repeat (50) tick();
        load_en = 1'b1; load_ch = 2'd0; load_val = 30;
        push_exp(c + 52, 4'b0001);
        tick(); load_en = 1'b0;
        tick();
        check("lower_limit_idle", busy, 4'b0000);
        load(0, 0);
        c = cyc;
        trig = 4'b0001;
        push_exp(c + 2, 4'b0001);
        tick(); trig = '0;
        check("lim0_busy", busy, 4'b0001);
        tick();
        check("lim0_idle", busy, 4'b0000);
        repeat (3) tick();

        // 6: concurrency with limits 3,3,7,0, then held trig on ch3 with limit 1
        load(0, 3); load(1, 3); load(2, 7); load(3, 0);
        c = cyc;
        trig = 4'b1111;
        push_exp(c + 2, 4'b1000);
        push_exp(c + 5, 4'b0011);
        push_exp(c + 9, 4'b0100);
        tick(); trig = '0;
        repeat (12) tick();
        load(3, 1);
        c = cyc;
        trig = 4'b1000;
        push_exp(c + 3, 4'b1000);
        push_exp(c + 5, 4'b1000);
        push_exp(c + 7, 4'b1000);
        push_exp(c + 9, 4'b1000);
        repeat (8) tick();
        trig = '0;
        repeat (5) tick();
        check("held_trig_idle", busy, 4'b0000);

        guard = 0;
        while (expq.size() > 0 && guard < 400) begin
            tick();
            guard++;
        end
        n_chk++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", expq.size());
        end
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
